// File: rtl/invader_fire_sched_pkg.sv
// Shared constants for the invader grid: geometry, sprite pitch, fire-scheduler
// state encoding and the LFSR feedback mask.
package invader_fire_sched_pkg;

  localparam int INV_ROWS   = 5;
  localparam int INV_COLS   = 11;
  localparam int INV_CELLS  = INV_ROWS * INV_COLS;
  localparam int INV_CELL_W = 32;
  localparam int INV_CELL_H = 24;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    SCAN  = 2'd2,
    OFFER = 2'd3
  } fire_state_e;

  function automatic logic [3:0] wrap_col(input logic [3:0] r);
    return (r >= 4'(INV_COLS)) ? r - 4'(INV_COLS) : r;
  endfunction

endpackage

// File: rtl/invader_fire_sched_if.sv
// Spawn handshake between the fire scheduler (master) and the enemy-bullet engine.
interface invader_fire_sched_if;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [1:0] spawn_slot;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic [5:0] spawn_invader;

  modport master (
    output spawn_valid, spawn_slot, spawn_x, spawn_y, spawn_invader,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid, spawn_slot, spawn_x, spawn_y, spawn_invader,
    output spawn_ready
  );
endinterface

// File: rtl/invader_fire_sched_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, reusable for any pseudo-random effect.
module lfsr16
  import invader_fire_sched_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

  // NOTE: clocked state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/invader_fire_sched.sv
// Enemy fire scheduler: picks a random column, finds its bottom-most live invader
// and offers a bullet spawn. Define FIRE_SPEEDUP_EN to shorten cooldown as the grid thins.
module invader_fire_sched
  import invader_fire_sched_pkg::*;
#(
  parameter int          NUM_SLOTS   = 3,
  parameter int          FIRE_PERIOD = 60,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_i,
  input  logic                  enable_i,
  input  logic [INV_CELLS-1:0]  invaders_i,
  input  logic [9:0]            invaders_x_i,
  input  logic [9:0]            invaders_y_i,
  input  logic [NUM_SLOTS-1:0]  slot_free_i,
  invader_fire_sched_if.master  spawn
);

  localparam logic [7:0] PERIOD   = 8'(FIRE_PERIOD);
  localparam logic [2:0] TOP_ROW  = 3'(INV_ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'(INV_COLS - 1);

  fire_state_e          state_q, state_d;
  logic [INV_CELLS-1:0] snap_q;
  logic [9:0]           ox_q, oy_q;
  logic [1:0]           slot_q, first_free;
  logic [3:0]           col_q, tried_q;
  logic [2:0]           row_q;
  logic [7:0]           cool_q, reload;
  logic [15:0]          lfsr;
  logic                 unused_lfsr_hi;
  logic [5:0]           cell_idx;
  logic                 cell_alive, trigger, handshake;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .lfsr_o(lfsr));
  assign unused_lfsr_hi = ^lfsr[15:4];

  assign cell_idx   = 6'(row_q) * 6'(INV_COLS) + 6'(col_q);
  assign cell_alive = snap_q[cell_idx];
  assign trigger    = frame_i & enable_i & (cool_q == '0) & (|slot_free_i) & (|invaders_i);
  assign handshake  = (state_q == OFFER) & spawn.spawn_ready;

  always_comb begin
    first_free = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (slot_free_i[i]) first_free = 2'(i);
  end

`ifdef FIRE_SPEEDUP_EN
  logic [5:0] alive_cnt;
  always_comb begin
    alive_cnt = '0;
    for (int i = 0; i < INV_CELLS; i++) alive_cnt = alive_cnt + 6'(snap_q[i]);
    if (alive_cnt <= 6'd11)      reload = PERIOD >> 2;
    else if (alive_cnt <= 6'd27) reload = PERIOD >> 1;
    else                         reload = PERIOD;
    if (reload == '0) reload = 8'd1;
  end
`else
  assign reload = PERIOD;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: next-state defaults to the current state before the case so no
  // path leaves state_d unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (trigger) state_d = PICK;
      PICK:  state_d = enable_i ? SCAN : IDLE;
      SCAN: begin
        if (!enable_i)       state_d = IDLE;
        else if (cell_alive) state_d = OFFER;
        else if (row_q == '0 && tried_q == LAST_COL) state_d = IDLE;
      end
      OFFER: if (spawn.spawn_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the snapshot is ordinary flops, not a RAM, so it takes the reset
  // like every other register and the outputs are defined from the first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      slot_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      tried_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (trigger) begin
          snap_q <= invaders_i;
          ox_q   <= invaders_x_i;
          oy_q   <= invaders_y_i;
          slot_q <= first_free;
        end
        PICK: begin
          col_q   <= wrap_col(lfsr[3:0]);
          row_q   <= TOP_ROW;
          tried_q <= '0;
        end
        SCAN: if (enable_i && !cell_alive) begin
          if (row_q != '0) begin
            row_q <= row_q - 3'd1;
          end else begin
            col_q   <= (col_q == LAST_COL) ? '0 : col_q + 4'd1;
            row_q   <= TOP_ROW;
            tried_q <= tried_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Reload wins over a frame arriving on the handshake cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            cool_q <= PERIOD;
    else if (handshake)                 cool_q <= reload;
    else if (frame_i && cool_q != '0)   cool_q <= cool_q - 8'd1;
  end

  always_comb begin
    spawn.spawn_valid   = 1'b0;
    spawn.spawn_slot    = '0;
    spawn.spawn_x       = '0;
    spawn.spawn_y       = '0;
    spawn.spawn_invader = '0;
    if (state_q == OFFER) begin
      spawn.spawn_valid   = 1'b1;
      spawn.spawn_slot    = slot_q;
      spawn.spawn_x       = ox_q + 10'(col_q) * 10'(INV_CELL_W) + 10'(INV_CELL_W / 2);
      spawn.spawn_y       = oy_q + (10'(row_q) + 10'd1) * 10'(INV_CELL_H);
      spawn.spawn_invader = cell_idx + 6'd1;
    end
  end

endmodule

// File: tb/tb_invader_fire_sched.sv
// Randomized scoreboard bench for invader_fire_sched: a cycle-counting reference
// model predicts each shot; a negedge monitor pops and compares.
module tb_invader_fire_sched;

  localparam int          P    = 4;
  localparam int          NS   = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          CW   = 32;
  localparam int          CH   = 24;

  typedef struct {
    int slot;
    int x;
    int y;
    int inv;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame;
  logic          enable;
  logic [54:0]   invaders;
  logic [9:0]    ox, oy;
  logic [NS-1:0] slot_free;

  invader_fire_sched_if sp();

  invader_fire_sched #(.NUM_SLOTS(NS), .FIRE_PERIOD(P), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .frame_i(frame), .enable_i(enable),
    .invaders_i(invaders), .invaders_x_i(ox), .invaders_y_i(oy),
    .slot_free_i(slot_free), .spawn(sp)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int pick_col(input logic [15:0] l);
    int v;
    v = int'(l[3:0]);
    return (v >= 11) ? v - 11 : v;
  endfunction

  // Walk columns from c0, bottom row upward; one scan cycle per tested cell
  function automatic void scan(input logic [54:0] s, input int c0,
                               output int steps, output int row, output int col);
    steps = 0; row = 0; col = c0;
    for (int t = 0; t < 11; t++) begin
      for (int r = 4; r >= 0; r--) begin
        steps++;
        if (s[r*11 + (c0 + t) % 11]) begin
          row = r; col = (c0 + t) % 11;
          return;
        end
      end
    end
  endfunction

  function automatic int reload_for(input logic [54:0] s);
`ifdef FIRE_SPEEDUP_EN
    int n, v;
    n = 0;
    for (int i = 0; i < 55; i++) n += int'(s[i]);
    v = (n <= 11) ? P / 4 : (n <= 27) ? P / 2 : P;
    return (v < 1) ? 1 : v;
`else
    return (s != '0) ? P : P;
`endif
  endfunction

  // ---------------- reference model ----------------
  exp_t        exp_q[$];
  int          cyc = 0;
  logic [15:0] m_lfsr = SEED;
  int          m_cool = P;
  int          m_phase = 0;  // 0 idle, 1 picking/scanning, 2 offering
  int          t_offer = 0;
  bit          m_valid = 0;
  logic [54:0] m_snap = '0;
  int          cool_pre, steps, rr, cc, fs;
  exp_t        e;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      cyc = 0; m_lfsr = SEED; m_cool = P; m_phase = 0; m_valid = 0;
      exp_q.delete();
    end else begin
      cyc++;
      cool_pre = m_cool;
      m_lfsr = lfsr_step(m_lfsr);
      if (m_phase == 2 && sp.spawn_ready) begin
        m_cool = reload_for(m_snap);
        m_phase = 0; m_valid = 0;
      end else if (frame && m_cool > 0) begin
        m_cool--;
      end
      if (m_phase == 0 && !m_valid && frame && enable && cool_pre == 0 &&
          slot_free != '0 && invaders != '0 && !(cool_pre == 0 && m_cool != 0)) begin
        fs = 0;
        for (int i = NS - 1; i >= 0; i--) if (slot_free[i]) fs = i;
        scan(invaders, pick_col(m_lfsr), steps, rr, cc);
        e.slot = fs;
        e.x    = (int'(ox) + cc * CW + CW / 2) & 1023;
        e.y    = (int'(oy) + (rr + 1) * CH) & 1023;
        e.inv  = rr * 11 + cc + 1;
        e.cyc  = cyc + 1 + steps;
        exp_q.push_back(e);
        m_snap = invaders; t_offer = e.cyc; m_phase = 1;
      end else if (m_phase == 1) begin
        if (!enable) begin
          m_phase = 0;
          void'(exp_q.pop_back());
        end else if (cyc == t_offer) begin
          m_phase = 2; m_valid = 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  exp_t cur;
  bit   prev_v = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_v = 0;
    end else begin
      check("valid", sp.spawn_valid, m_valid);
      if (sp.spawn_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_spawn: got valid at cycle %0d, expected no pending shot", cyc);
        end else begin
          cur = exp_q.pop_front();
          check("slot", sp.spawn_slot, cur.slot);
          check("x", sp.spawn_x, cur.x);
          check("y", sp.spawn_y, cur.y);
          check("invader", sp.spawn_invader, cur.inv);
          check("rise_cycle", cyc, cur.cyc);
        end
      end else if (sp.spawn_valid) begin
        check("hold_slot", sp.spawn_slot, cur.slot);
        check("hold_x", sp.spawn_x, cur.x);
        check("hold_y", sp.spawn_y, cur.y);
        check("hold_invader", sp.spawn_invader, cur.inv);
      end
      prev_v = sp.spawn_valid;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_frame(input bit en);
    frame = 1; enable = en;
    @(negedge clk);
    frame = 0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_cool != 0 && n < 300) begin
      pulse_frame(0);
      n++;
    end
    enable = 1;
  endtask

  task automatic fire_at_col(input int col, output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (pick_col(lfsr_step(m_lfsr)) == col) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL pick_wait: column %0d not reached, expected within 400 cycles", col);
    end else begin
      frame = 1;
      @(negedge clk);
      frame = 0;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!sp.spawn_valid && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    if (!sp.spawn_valid) begin
      checks++; failures++;
      $display("FAIL valid_timeout: got no spawn_valid, expected within 80 cycles");
    end
  endtask

  task automatic accept(input int delay, input bit frame_mid);
    for (int i = 0; i < delay; i++) begin
      frame = frame_mid && (i == 3);
      @(negedge clk);
    end
    frame = 0;
    sp.spawn_ready = 1;
    @(negedge clk);
    sp.spawn_ready = 0;
    check("drop_after_handshake", sp.spawn_valid, 0);
  endtask

  task automatic watch(input int n, output bit seen);
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (sp.spawn_valid) seen = 1;
    end
  endtask

  task automatic shoot(input int col, input int delay, input bit frame_mid,
                       output int lat, output exp_t got);
    bit ok;
    lat = -1;
    got = '{default: -1};
    drain();
    fire_at_col(col, ok);
    if (ok) begin
      wait_valid(lat);
      got.slot = sp.spawn_slot;
      got.x    = sp.spawn_x;
      got.y    = sp.spawn_y;
      got.inv  = sp.spawn_invader;
      if (sp.spawn_valid) accept(delay, frame_mid);
    end
  endtask

  int   lat, n;
  bit   seen;
  exp_t got;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected completion before 400 us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; frame = 0; enable = 0; invaders = '0; ox = '0; oy = '0;
    slot_free = '0; sp.spawn_ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset_valid", sp.spawn_valid, 0);
    check("reset_slot", sp.spawn_slot, 0);
    check("reset_x", sp.spawn_x, 0);
    check("reset_y", sp.spawn_y, 0);
    check("reset_invader", sp.spawn_invader, 0);

    // Full grid, column 3: bottom row fires at frame+3
    invaders = '1; ox = 10'd100; oy = 10'd50; slot_free = 3'b111;
    shoot(3, 0, 0, lat, got);
    check("full_latency", lat, 3);
    check("full_x", got.x, 212);
    check("full_y", got.y, 170);
    check("full_invader", got.inv, 48);
    check("full_slot", got.slot, 0);

    // Column 3 alive only at row 1: four scan cycles
    invaders = '1;
    invaders[3] = 0; invaders[25] = 0; invaders[36] = 0; invaders[47] = 0;
    shoot(3, 0, 0, lat, got);
    check("col3_latency", lat, 6);
    check("col3_invader", got.inv, 15);
    check("col3_y", got.y, 98);

    // Lone invader 55, start at column 0: scan wraps across the grid
    invaders = 55'(1) << 54;
    shoot(0, 0, 0, lat, got);
    check("lone_invader", got.inv, 55);

    // All dead: no trigger
    invaders = '0;
    drain();
    pulse_frame(1);
    watch(10, seen);
    check("all_dead_no_shot", seen, 0);

    // Slot selection and no free slot
    invaders = '1; slot_free = 3'b110;
    shoot($urandom_range(0, 10), 0, 0, lat, got);
    check("slot_110", got.slot, 1);
    slot_free = 3'b000;
    drain();
    pulse_frame(1);
    watch(10, seen);
    check("no_slot_no_shot", seen, 0);

    // Held-off ready with a frame during the offer
    slot_free = 3'b111;
    shoot($urandom_range(0, 10), 10, 1, lat, got);

    // Enable dropped mid-scan
    invaders = 55'(1) << 54;
    drain();
    begin
      bit ok;
      fire_at_col(0, ok);
    end
    repeat (5) @(negedge clk);
    enable = 0;
    watch(60, seen);
    check("abort_no_shot", seen, 0);
    enable = 1;

    // Reset while offering; cooldown restarts at FIRE_PERIOD
    invaders = '1;
    drain();
    frame = 1; @(negedge clk); frame = 0;
    wait_valid(lat);
    #2 rst = 1;
    #1 check("async_reset_drop", sp.spawn_valid, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    repeat (P - 1) pulse_frame(0);
    enable = 1;
    frame = 1; @(negedge clk); frame = 0;
    watch(10, seen);
    check("no_shot_before_period", seen, 0);
    frame = 1; @(negedge clk); frame = 0;
    wait_valid(lat);
    check("shot_at_period", sp.spawn_valid, 1);
    if (sp.spawn_valid) accept(0, 0);

    // Randomized shots
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 2))
        0:       invaders = 55'({$urandom(), $urandom()});
        1:       invaders = 55'({$urandom(), $urandom()}) & 55'({$urandom(), $urandom()}) &
                            55'({$urandom(), $urandom()});
        default: invaders = 55'(1) << $urandom_range(0, 54);
      endcase
      if (invaders == '0) invaders[0] = 1;
      ox = 10'($urandom()); oy = 10'($urandom());
      slot_free = 3'($urandom_range(1, 7));
      shoot($urandom_range(0, 10), $urandom_range(0, 5), 0, lat, got);
    end

    // Frame gap after a shot with 10 invaders alive
    invaders = 55'h3FF; slot_free = 3'b111;
    shoot($urandom_range(0, 9), 0, 0, lat, got);
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      frame = 1; @(negedge clk); frame = 0;
      n++;
      repeat (62) begin
        @(negedge clk);
        if (sp.spawn_valid) seen = 1;
      end
    end
`ifdef FIRE_SPEEDUP_EN
    check("frame_gap", n, ((P / 4 < 1) ? 1 : P / 4) + 1);
`else
    check("frame_gap", n, P + 1);
`endif
    if (sp.spawn_valid) accept(0, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
